pram_rd_pack16to32: RTL and testbench

Read-side buffer between the pSRAM read datapath and the video output pipeline. It takes 16-bit half-words returned by the pSRAM controller and reassembles them into 32-bit pixel words, inverting the 32→16 split performed on the write side. The words are held in a single-clock FIFO. Its programmable-full flag throttles pSRAM read-burst requests; its empty flag paces the video reader.

---
 rtl/pram_pkg.sv | 15 +
 rtl/pram_rd_sync_ram.sv | 43 ++++
 rtl/pram_rd_pack16to32.sv | 124 ++++++++++++
 tb/tb_pram_rd_pack16to32.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pram_pkg.sv
// Shared definitions for the pSRAM read-side datapath.
// Provides the half-word and word widths used on both sides of the
// 16-to-32 packer, and the pairing-state enum for the half-word assembler.
package pram_pkg;

  localparam int PRAM_HALF_W = 16;
  localparam int PRAM_WORD_W = 32;

  // EVEN: no half latched. ODD: first half latched, waiting for the second.
  typedef enum logic {
    PAIR_EVEN = 1'b0,
    PAIR_ODD  = 1'b1
  } pair_state_t;

endpackage

// File: rtl/pram_rd_sync_ram.sv
// Simple dual-port RAM, DEPTH x 32, one clock.
// The read port is registered and that register doubles as the FIFO's
// rdata output, so it is the only part with a reset; storage is not reset.
// Ports:
//   clk, reset_n     - clock, async active-low reset (read register only)
//   we, waddr, wdata - write port
//   re, raddr        - read enable and address; rdata holds when re is low
//   rdata            - registered read data
module pram_rd_sync_ram
  import pram_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [PRAM_WORD_W-1:0] wdata,
  input  logic                   re,
  input  logic [AW-1:0]          raddr,
  output logic [PRAM_WORD_W-1:0] rdata
);

  logic [PRAM_WORD_W-1:0] mem [DEPTH];

  // Storage write; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; holds the last popped word between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pram_rd_pack16to32.sv
// Read-side packer FIFO: pairs 16-bit half-words from the pSRAM controller
// into 32-bit pixel words and buffers them for the video reader.
// Optional build macro: PRAM_RD_HALF_SWAP_EN (first beat is the high half).
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   flush         - synchronous clear (frame start), beats wen/ren
//   wdata, wen    - incoming half-word and its valid
//   ren, rdata    - pop request and popped word (registered, holds)
//   rempty, wfull - no words stored / DEPTH words stored
//   prog_full     - count >= PROG_FULL_TH, throttles read bursts
//   half_pending  - a first half is latched awaiting its partner
//   count         - number of complete words stored
module pram_rd_pack16to32
  import pram_pkg::*;
#(
  parameter  int DEPTH        = 256,
  parameter  int PROG_FULL_TH = 192,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [PRAM_HALF_W-1:0] wdata,
  input  logic                   wen,
  input  logic                   ren,
  output logic [PRAM_WORD_W-1:0] rdata,
  output logic                   rempty,
  output logic                   wfull,
  output logic                   prog_full,
  output logic                   half_pending,
  output logic [CW-1:0]          count
);

  pair_state_t            state;
  logic [PRAM_HALF_W-1:0] half_reg;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   wr_accept;
  logic                   word_write;
  logic                   rd_accept;
  logic [CW-1:0]          count_next;
  logic [PRAM_WORD_W-1:0] word;

  // Acceptance uses the registered flags of this cycle; flush masks both
  // sides so nothing reaches memory or the read register during a clear.
  assign wr_accept  = wen && !wfull && !flush;
  assign word_write = wr_accept && (state == PAIR_ODD);
  assign rd_accept  = ren && !rempty && !flush;

`ifdef PRAM_RD_HALF_SWAP_EN
  assign word = {half_reg, wdata};
`else
  assign word = {wdata, half_reg};
`endif

  // Next fill level; a simultaneous write and read cancel out.
  always_comb begin
    count_next = count;
    if (word_write && !rd_accept) begin
      count_next = count + 1'b1;
    end else if (!word_write && rd_accept) begin
      count_next = count - 1'b1;
    end
  end

  // Pairing FSM, pointers, count and registered flags. The flags are taken
  // from count_next so they line up with count after every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PAIR_EVEN;
      half_pending <= 1'b0;
      half_reg     <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rempty       <= 1'b1;
      wfull        <= 1'b0;
      prog_full    <= 1'b0;
    end else if (flush) begin
      state        <= PAIR_EVEN;
      half_pending <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rempty       <= 1'b1;
      wfull        <= 1'b0;
      prog_full    <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (state == PAIR_EVEN) begin
          half_reg     <= wdata;
          state        <= PAIR_ODD;
          half_pending <= 1'b1;
        end else begin
          state        <= PAIR_EVEN;
          half_pending <= 1'b0;
          wptr         <= wptr + 1'b1;
        end
      end
      if (rd_accept) begin
        rptr <= rptr + 1'b1;
      end
      count     <= count_next;
      rempty    <= (count_next == '0);
      wfull     <= (count_next == CW'(DEPTH));
      prog_full <= (count_next >= CW'(PROG_FULL_TH));
    end
  end

  pram_rd_sync_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (word_write),
    .waddr   (wptr),
    .wdata   (word),
    .re      (rd_accept),
    .raddr   (rptr),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_pram_rd_pack16to32.sv
// Scoreboard bench for pram_rd_pack16to32 (DEPTH=16, PROG_FULL_TH=12).
// A queue-based reference FIFO predicts fill level, flags and popped words;
// a separate monitor compares rdata whenever the DUT accepts a read.
module tb_pram_rd_pack16to32;

  localparam int DEPTH = 16;
  localparam int TH    = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic [15:0]   wdata;
  logic          wen;
  logic          ren;
  logic [31:0]   rdata;
  logic          rempty;
  logic          wfull;
  logic          prog_full;
  logic          half_pending;
  logic [CW-1:0] count;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] expq[$];
  logic [15:0] mhalf;
  bit          mhalf_v;
  logic [31:0] mlast;

  pram_rd_pack16to32 #(
    .DEPTH        (DEPTH),
    .PROG_FULL_TH (TH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wdata        (wdata),
    .wen          (wen),
    .ren          (ren),
    .rdata        (rdata),
    .rempty       (rempty),
    .wfull        (wfull),
    .prog_full    (prog_full),
    .half_pending (half_pending),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [15:0] first, input logic [15:0] second);
`ifdef PRAM_RD_HALF_SWAP_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  task automatic checkOutput();
    checkOne("count", 32'(count), 32'(mq.size()));
    checkOne("rempty", 32'(rempty), 32'(mq.size() == 0));
    checkOne("wfull", 32'(wfull), 32'(mq.size() == DEPTH));
    checkOne("prog_full", 32'(prog_full), 32'(mq.size() >= TH));
    checkOne("half_pending", 32'(half_pending), 32'(mhalf_v));
    checkOne("rdata_hold", rdata, mlast);
  endtask

  // One clock of stimulus; the model decides acceptance from its own
  // fill level before the edge, just like the FIFO's current-cycle flags.
  task automatic applyStimulus(input bit w, input logic [15:0] d, input bit r, input bit f);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    wen = w; wdata = d; ren = r; flush = f;
    if (f) begin
      mq.delete();
      mhalf_v = 1'b0;
    end else begin
      rd_ok = r && (mq.size() != 0);
      wr_ok = w && (mq.size() != DEPTH);
      if (rd_ok) begin
        mlast = mq.pop_front();
        expq.push_back(mlast);
      end
      if (wr_ok) begin
        if (mhalf_v) begin
          mq.push_back(pack(mhalf, d));
          mhalf_v = 1'b0;
        end else begin
          mhalf   = d;
          mhalf_v = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
    reset_n = 1'b0;
    #2;
    mq.delete();
    mhalf_v = 1'b0;
    mlast   = '0;
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: whenever the DUT accepts a read, the word appears on rdata
  // right after the edge and must match the oldest expected word.
  always @(posedge clk) begin
    if (reset_n && !flush && ren && !rempty) begin
      #1;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("[TB] FAIL read_unexpected: got %h expected no read at %0t", rdata, $time);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        if (rdata !== e) begin
          failures++;
          $display("[TB] FAIL read_data: got %h expected %h at %0t", rdata, e, $time);
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    mhalf = '0; mhalf_v = 1'b0; mlast = '0;
    #12;
    doReset();

    // Basic pairing
    applyStimulus(1, 16'h1111, 0, 0);
    applyStimulus(1, 16'h2222, 0, 0);
    applyStimulus(1, 16'h3333, 0, 0);
    applyStimulus(1, 16'h4444, 0, 0);
    applyStimulus(0, 16'h0, 1, 0);
`ifdef PRAM_RD_HALF_SWAP_EN
    checkOne("basic_word0", rdata, 32'h11112222);
`else
    checkOne("basic_word0", rdata, 32'h22221111);
`endif
    applyStimulus(0, 16'h0, 1, 0);
`ifdef PRAM_RD_HALF_SWAP_EN
    checkOne("basic_word1", rdata, 32'h33334444);
`else
    checkOne("basic_word1", rdata, 32'h44443333);
`endif
    checkOne("basic_empty", 32'(rempty), 32'd1);

    // Fill past full with no reads; beats 33-34 must be dropped
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1, 16'(i * 16'h0101 + 16'h0a00), 0, 0);
    end
    checkOne("fill_count", 32'(count), 32'd16);
    checkOne("fill_wfull", 32'(wfull), 32'd1);

    // Full boundary: read with a beat, write lost, read proceeds
    applyStimulus(1, 16'hbeef, 1, 0);
    checkOne("full_boundary_count", 32'(count), 32'd15);

    // Drain, then empty boundary
    while (mq.size() != 0) applyStimulus(0, 16'h0, 1, 0);
    applyStimulus(1, 16'hc0de, 0, 0);
    applyStimulus(1, 16'hf00d, 1, 0);
    checkOne("empty_boundary_count", 32'(count), 32'd1);
    applyStimulus(0, 16'h0, 1, 0);

    // Mid-word flush, then mid-word reset
    applyStimulus(1, 16'haaaa, 0, 0);
    checkOne("mid_half_pending", 32'(half_pending), 32'd1);
    applyStimulus(1, 16'h9999, 1, 1);
    applyStimulus(1, 16'h5555, 0, 0);
    applyStimulus(1, 16'h6666, 0, 0);
    applyStimulus(0, 16'h0, 1, 0);
    applyStimulus(1, 16'haaaa, 0, 0);
    doReset();
    applyStimulus(1, 16'h5555, 0, 0);
    applyStimulus(1, 16'h6666, 0, 0);
    applyStimulus(0, 16'h0, 1, 0);
`ifdef PRAM_RD_HALF_SWAP_EN
    checkOne("after_reset_word", rdata, 32'h55556666);
`else
    checkOne("after_reset_word", rdata, 32'h66665555);
`endif

    // Randomized traffic with phases biased towards fill and drain
    for (int i = 0; i < 900; i++) begin
      int wp;
      int rp;
      wp = (i % 300 < 150) ? 85 : 30;
      rp = (i % 300 < 150) ? 20 : 70;
      applyStimulus(($urandom_range(99) < wp), 16'($urandom), ($urandom_range(99) < rp),
                    ($urandom_range(199) == 0));
    end

    applyStimulus(0, 16'h0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0);
    checkOne("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
